qpsk_seq_ctrl: RTL

Run-phase sequencer for the QPSK link. It generates the oversampling phase and symbol strobe, and gates the equalizer adaptation (LMS) and the BER sync/count enables through a fixed sequence: converge, latency sync, error-count window, done or fail. It replaces free-running start counters with an explicit state machine and sits between the board switch/reset and the transmitter, adaptive filter and BER blocks.

---
 rtl/qpsk_seq_ctrl_if.sv | 31 +++
 rtl/qpsk_seq_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/qpsk_seq_ctrl_if.sv
// Control/status bundle between the QPSK run-phase sequencer and its neighbours.
// The slave side is the sequencer; the master side is the board/test driver.
interface qpsk_seq_ctrl_if #(
    parameter int OVERSAMP = 4
);
    localparam int PH_W = $clog2(OVERSAMP);

    logic            i_sw;
    logic            i_syn_lock;
    logic [PH_W-1:0] o_phase;
    logic            o_sym_en;
    logic            o_lms_en;
    logic            o_syn_en;
    logic            o_cnt_en;
    logic [2:0]      o_state;
    logic            o_done;
    logic            o_fail;
    logic [7:0]      o_resync_cnt;

    modport slave (
        input  i_sw, i_syn_lock,
        output o_phase, o_sym_en, o_lms_en, o_syn_en, o_cnt_en,
               o_state, o_done, o_fail, o_resync_cnt
    );

    modport master (
        output i_sw, i_syn_lock,
        input  o_phase, o_sym_en, o_lms_en, o_syn_en, o_cnt_en,
               o_state, o_done, o_fail, o_resync_cnt
    );
endinterface

// File: rtl/qpsk_seq_ctrl.sv
// QPSK run-phase sequencer: oversampling phase/strobe generation and the
// converge -> sync -> count -> done/fail gating of the LMS and BER blocks.
module qpsk_seq_ctrl #(
    parameter int OVERSAMP  = 4,
    parameter int CONV_SYMB = 352590,
    parameter int SYNC_TMO  = 261121,
    parameter int CNT_SYMB  = 261121,
    parameter int NB_CNT    = 24
) (
    input  logic             clk,
    input  logic             i_reset,
    qpsk_seq_ctrl_if.slave   bus
);
    localparam int PH_W = $clog2(OVERSAMP);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(OVERSAMP - 1);
    localparam logic [NB_CNT-1:0] CONV_LAST = NB_CNT'(CONV_SYMB - 1);
    localparam logic [NB_CNT-1:0] SYNC_LAST = NB_CNT'(SYNC_TMO - 1);
    localparam logic [NB_CNT-1:0] CNT_LAST  = NB_CNT'(CNT_SYMB - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CONVERGE = 3'd1,
        SYNC     = 3'd2,
        COUNT    = 3'd3,
        DONE     = 3'd4,
        FAIL     = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              run_q, run_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [NB_CNT-1:0] symCnt_q, symCnt_d;
    logic [7:0]        resyncCnt_q, resyncCnt_d;
    logic              symEn;

    assign symEn = run_q && (phase_q == '0);

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            phase_q     <= '0;
            symCnt_q    <= '0;
            resyncCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            phase_q     <= phase_d;
            symCnt_q    <= symCnt_d;
            resyncCnt_q <= resyncCnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        run_d       = bus.i_sw;
        phase_d     = '0;
        symCnt_d    = symCnt_q;
        resyncCnt_d = resyncCnt_q;

        if (run_q) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end

        // Lock level is only trusted on strobe cycles; between strobes nothing moves.
        if (symEn) begin
            symCnt_d = symCnt_q + NB_CNT'(1);
            case (state_q)
                IDLE: begin
                    state_d     = CONVERGE;
                    resyncCnt_d = '0;
                end
                CONVERGE: begin
                    if (symCnt_q == CONV_LAST) state_d = SYNC;
                end
                SYNC: begin
                    if (bus.i_syn_lock)              state_d = COUNT;
                    else if (symCnt_q == SYNC_LAST)  state_d = FAIL;
                end
                COUNT: begin
                    if (!bus.i_syn_lock) begin
                        state_d = SYNC;
                        if (resyncCnt_q != 8'hFF) resyncCnt_d = resyncCnt_q + 8'd1;
                    end else if (symCnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        if (state_d != state_q) symCnt_d = '0;

        // Abort wins over any transition but leaves the resync history intact.
        if (!bus.i_sw) begin
            state_d     = IDLE;
            run_d       = 1'b0;
            phase_d     = '0;
            symCnt_d    = '0;
            resyncCnt_d = resyncCnt_q;
        end
    end

    assign bus.o_phase      = phase_q;
    assign bus.o_sym_en     = symEn;
    assign bus.o_lms_en     = (state_q == CONVERGE) || (state_q == SYNC) ||
                              (state_q == COUNT)    || (state_q == DONE);
    assign bus.o_syn_en     = (state_q == SYNC);
    assign bus.o_cnt_en     = (state_q == COUNT);
    assign bus.o_state      = state_q;
    assign bus.o_done       = (state_q == DONE);
    assign bus.o_fail       = (state_q == FAIL);
    assign bus.o_resync_cnt = resyncCnt_q;
endmodule
